// File: rtl/input_port_pkg.sv
// Shared defaults and sizing helpers for the input port.
package input_port_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

    // Pointer width for a buffer of the given (power-of-two) depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/input_port_if.sv
// Bundle of the external-source handshake, the W-bus drive and the status flags.
//
// Handshake: a byte moves from the source into the port on a rising edge where
// ext_valid and ext_ready are both high. ext_ready depends only on registered
// state, never on ext_valid. Once ext_valid is raised, the source holds it
// (and ext_data) until that edge. On the W-bus side, the head byte is taken
// on a rising edge where nEi is low and the port is not empty.
import input_port_pkg::*;

interface input_port_if #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = ptr_w(DEPTH) + 1;

    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             nEi;
    logic [WIDTH-1:0] wbus_out;
    logic             wbus_oe;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             underrun;

    modport slave (
        input  ext_data, ext_valid, nEi,
        output ext_ready, wbus_out, wbus_oe, empty, full, count, underrun
    );

    modport master (
        output ext_data, ext_valid, nEi,
        input  ext_ready, wbus_out, wbus_oe, empty, full, count, underrun
    );

endinterface

// File: rtl/input_port_fifo.sv
// Circular byte buffer: storage array, head/tail pointers and occupancy count.
// Callers must never push when full nor pop when empty.
import input_port_pkg::*;

module input_port_fifo #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic [ptr_w(DEPTH):0]       count,
    output logic                        empty,
    output logic                        full
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks net occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= wdata;
    end

    assign rdata = mem[head_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/input_port.sv
// Input port: buffers bytes from an external source and drives the head byte
// onto the W bus while nEi is low. Optional sticky underrun flag enabled by
// defining INPUT_PORT_UNDERRUN_FLAG_EN; otherwise underrun is tied low.
import input_port_pkg::*;

module input_port #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         CLK,
    input  logic         nCLR,
    input_port_if.slave  bus
);
    localparam int CW = ptr_w(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_data;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // A byte pushed into an empty buffer is not visible until the next cycle,
    // so pop is qualified by the registered empty flag only.
    assign push = bus.ext_valid && !fifo_full;
    assign pop  = !bus.nEi && !fifo_empty;

    input_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nCLR),
        .push  (push),
        .pop   (pop),
        .wdata (bus.ext_data),
        .rdata (head_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.ext_ready = !fifo_full;
    assign bus.wbus_oe   = pop;
    assign bus.wbus_out  = pop ? head_data : '0;
    assign bus.empty     = fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.count     = fifo_count;

`ifdef INPUT_PORT_UNDERRUN_FLAG_EN
    logic underrun_q;

    // Sticky: set by any enable while empty, cleared only by reset.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            underrun_q <= 1'b0;
        end else if (!bus.nEi && fifo_empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of the port.
module tb_input_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef INPUT_PORT_UNDERRUN_FLAG_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic CLK;
    logic nCLR;

    input_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard state
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_under;
    int               checks;
    int               failures;
    logic [WIDTH-1:0] got_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model says the port should show now.
    task automatic check_model(input string tag);
        logic oe_e;
        oe_e = !bus.nEi && (exp_q.size() > 0);
        chk({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(exp_q.size() == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(exp_q.size() == DEPTH));
        chk({tag, "_ready"}, 32'(bus.ext_ready), 32'(exp_q.size() < DEPTH));
        chk({tag, "_oe"},    32'(bus.wbus_oe), 32'(oe_e));
        chk({tag, "_out"},   32'(bus.wbus_out), oe_e ? 32'(exp_q[0]) : 32'd0);
        chk({tag, "_under"}, 32'(bus.underrun), 32'(exp_under));
    endtask

    // One clock: drive at the falling edge, check, then apply the model at the rising edge.
    task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] d,
                         input logic nei, output logic [WIDTH-1:0] out);
        bit do_pop;
        bit do_push;
        bus.ext_valid = v;
        bus.ext_data  = d;
        bus.nEi       = nei;
        #1;
        check_model(tag);
        out     = bus.wbus_out;
        do_pop  = !nei && (exp_q.size() > 0);
        do_push = v && (exp_q.size() < DEPTH);
        if (UF_EN && !nei && exp_q.size() == 0) exp_under = 1'b1;
        @(posedge CLK);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        @(negedge CLK);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_under = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] popped [4];
        checks   = 0;
        failures = 0;
        model_reset();
        bus.ext_valid = 1'b0;
        bus.ext_data  = '0;
        bus.nEi       = 1'b0;
        nCLR          = 1'b0;

        // Reset state, with nEi low to show the bus stays quiet under reset
        repeat (2) @(negedge CLK);
        #1;
        check_model("reset");
        chk("reset_oe_lit", 32'(bus.wbus_oe), 32'd0);
        bus.nEi = 1'b1;
        nCLR    = 1'b1;

        // First push on the first edge after release, three bytes with nEi high
        cycle("p1", 1'b1, 8'd1, 1'b1, o);
        cycle("p3", 1'b1, 8'd3, 1'b1, o);
        cycle("p5", 1'b1, 8'd5, 1'b1, o);
        bus.ext_valid = 1'b0;
        #1;
        chk("req033_count", 32'(bus.count), 32'd3);
        chk("req033_ready", 32'(bus.ext_ready), 32'd1);
        chk("req033_out", 32'(bus.wbus_out), 32'd0);

        // Drain in order
        for (int i = 0; i < 3; i++) cycle("drain3", 1'b0, 8'd0, 1'b0, popped[i]);
        chk("req034_b0", 32'(popped[0]), 32'd1);
        chk("req034_b1", 32'(popped[1]), 32'd3);
        chk("req034_b2", 32'(popped[2]), 32'd5);
        cycle("after_drain", 1'b0, 8'd0, 1'b1, o);

        // Fill to full across the pointer wrap, then an ignored push
        cycle("f7",  1'b1, 8'd7,  1'b1, o);
        cycle("f11", 1'b1, 8'd11, 1'b1, o);
        cycle("f13", 1'b1, 8'd13, 1'b1, o);
        cycle("f17", 1'b1, 8'd17, 1'b1, o);
        chk("req035_full", 32'(bus.full), 32'd1);
        cycle("f19_ignored", 1'b1, 8'd19, 1'b1, o);
        for (int i = 0; i < 4; i++) cycle("drain4", 1'b0, 8'd0, 1'b0, popped[i]);
        chk("req035_b0", 32'(popped[0]), 32'd7);
        chk("req035_b1", 32'(popped[1]), 32'd11);
        chk("req035_b2", 32'(popped[2]), 32'd13);
        chk("req035_b3", 32'(popped[3]), 32'd17);

        // Simultaneous push and pop at count=2
        cycle("s29", 1'b1, 8'd29, 1'b1, o);
        cycle("s31", 1'b1, 8'd31, 1'b1, o);
        cycle("s23", 1'b1, 8'd23, 1'b0, o);
        chk("req036_out", 32'(o), 32'd29);
        chk("req036_count", 32'(bus.count), 32'd2);
        cycle("sd0", 1'b0, 8'd0, 1'b0, popped[0]);
        cycle("sd1", 1'b0, 8'd0, 1'b0, popped[1]);
        chk("req036_b0", 32'(popped[0]), 32'd31);
        chk("req036_b1", 32'(popped[1]), 32'd23);

        // Push into empty with nEi low: push only
        cycle("emp_push", 1'b1, 8'd41, 1'b0, o);
        chk("req021_count", 32'(bus.count), 32'd1);
        cycle("emp_pop", 1'b0, 8'd0, 1'b0, o);
        chk("req021_out", 32'(o), 32'd41);

        // Enable while empty, underrun stickiness
        cycle("under", 1'b0, 8'd0, 1'b0, o);
        cycle("under_after", 1'b0, 8'd0, 1'b1, o);
        chk("req037_under", 32'(bus.underrun), 32'(UF_EN));
        cycle("u1", 1'b1, 8'd2, 1'b1, o);
        cycle("u2", 1'b1, 8'd4, 1'b1, o);
        cycle("u3", 1'b1, 8'd6, 1'b1, o);

        // Asynchronous reset between edges with three bytes held
        bus.ext_valid = 1'b0;
        bus.nEi       = 1'b0;
        #2;
        nCLR = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("req038_count", 32'(bus.count), 32'd0);
        @(negedge CLK);
        nCLR    = 1'b1;
        bus.nEi = 1'b1;
        cycle("post_rst_push", 1'b1, 8'd99, 1'b1, o);
        cycle("post_rst_pop", 1'b0, 8'd0, 1'b0, o);
        chk("post_rst_out", 32'(o), 32'd99);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) != 0 ? (i % 64 < 32) : 0), o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 Parameter WIDTH, default 8, W bus byte width.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, minimum 2.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 nCLR  input  1  reset, asynchronous, active-low.
REQ-005 ext_data  input  WIDTH  byte from external source (switches/keypad/host).
REQ-006 ext_valid  input  1  ext_data valid this cycle.
REQ-007 ext_ready  output  1  port accepts a byte this cycle.
REQ-008 nEi  input  1  active-low enable; place head byte on W bus, consume it.
REQ-009 wbus_out  output  WIDTH  head byte toward W bus.
REQ-010 wbus_oe  output  1  high while wbus_out is validly driven.
REQ-011 empty  output  1  no bytes buffered.
REQ-012 full  output  1  DEPTH bytes buffered.
REQ-013 count  output  log2(DEPTH)+1  bytes buffered, 0..DEPTH.
REQ-014 underrun  output  1  sticky flag (only with macro, REQ-029).

Function
REQ-015 Push occurs on a rising edge when ext_valid=1 and ext_ready=1; ext_data written at tail, tail pointer increments modulo DEPTH.
REQ-016 ext_ready SHALL equal !full, combinational from registered state; never depends on ext_valid.
REQ-017 Pop occurs on a rising edge when nEi=0 and empty=0; head pointer increments modulo DEPTH.
REQ-018 wbus_oe SHALL equal (!nEi && !empty); wbus_out SHALL equal head byte when wbus_oe=1, else all zeros.
REQ-019 Latency: byte pushed at edge k is readable on wbus_out in the cycle after edge k; no same-cycle fall-through.
REQ-020 Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
REQ-021 Empty with push and nEi=0 same cycle: push only, wbus_oe=0, count becomes 1.
REQ-022 Full: ext_ready=0, ext_valid ignored, contents unchanged; pop still allowed.
REQ-023 nEi=0 while empty: no pointer change, wbus_oe=0.
REQ-024 Pointers wrap from DEPTH-1 to 0 without data loss; count saturates never (bounded by REQ-016/REQ-023).
REQ-025 empty=(count==0), full=(count==DEPTH), both derived from registered count.

Reset
REQ-026 nCLR=0 SHALL asynchronously clear head, tail, count to 0; empty=1, full=0, ext_ready=1, wbus_oe=0, wbus_out=0, underrun=0.
REQ-027 Reset mid-operation discards all buffered bytes; storage array contents need not be cleared.
REQ-028 Deassertion of nCLR takes effect synchronously; first push accepted on first rising edge with nCLR=1.

Configuration
REQ-029 Macro INPUT_PORT_UNDERRUN_FLAG_EN defined: underrun set on rising edge where nEi=0 and empty=1; remains set until nCLR=0.
REQ-030 Macro undefined: underrun port present, tied to 0, no flag register synthesized.

Structure
REQ-031 Package input_port_pkg holds WIDTH/DEPTH defaults and pointer-width constant (log2 DEPTH).
REQ-032 One sub-module input_port_fifo: storage array, head/tail pointers, count; top level adds handshake, W bus gating, underrun flag.

Verification
REQ-033 Reset then push 8'd1,8'd3,8'd5 (nEi=1) -> count=3, ext_ready=1, wbus_oe=0, wbus_out=0.
REQ-034 Then nEi=0 three cycles -> wbus_out 8'd1,8'd3,8'd5 in order, wbus_oe=1 each cycle; then empty=1, wbus_oe=0.
REQ-035 Push 8'd7,8'd11,8'd13,8'd17 -> full=1, ext_ready=0; further ext_valid with 8'd19 ignored; pop all four -> 7,11,13,17 (wrap verified).
REQ-036 count=2, ext_valid=1 data 8'd23 with nEi=0 one cycle -> oldest byte on bus, count stays 2, 8'd23 at tail.
REQ-037 nEi=0 while empty -> wbus_oe=0, count=0; underrun=1 with macro defined, 0 without; persists until nCLR pulse.
REQ-038 nCLR pulsed low between clock edges with count=3 -> immediate count=0, empty=1, wbus_out=0 before next edge.
